xsimbus_arbiter: RTL
====================

Name: xsimbus_arbiter

Overview:
Round-robin bus arbiter and address decoder for the xSimBus interconnect. It shares the single system bus between up to N_MASTERS requesters, such as the xrv32i core fetch/LSU ports and future DMA engines. It enforces a bounded hold time with preemption, and inserts a one-cycle turnaround between owners. It muxes the owner's address onto the bus and decodes it into a 5-bit device ID and a 32-bit one-hot device select, matching the bus's 32-device slot map.

Parameters:
N_MASTERS, 4, number of bus masters (2..8)
ID_W, 2, width of master_id_out, equal to clog2(N_MASTERS)
MAX_HOLD, 8, maximum consecutive grant cycles while another master waits (1..255)
CNT_W, 8, width of the hold counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_in  in  N_MASTERS  per-master bus request, level, held until done
addr_in  in  N_MASTERS*32  flattened per-master addresses; master i uses bits [32i+31:32i]
grant_out  out  N_MASTERS  one-hot grant, registered
master_id_out  out  ID_W  index of current/last owner, registered
hold_flag_out  out  N_MASTERS  per-master stall, equal to req_in & ~grant_out, combinational
bus_addr_out  out  32  owner's address, or 0 when no grant
device_id_out  out  5  bus_addr_out[31:27], or 0 when no grant
device_sel_out  out  32  one-hot of device_id_out, or 0 when no grant
timeout_out  out  1  one-cycle pulse on forced preemption

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - state=IDLE, grant_out=0, master_id_out=0, hold_cnt=0, timeout_out=0.
  - last_owner=N_MASTERS-1, so master 0 has top priority first.
  - Because hold_flag_out is combinational, it equals req_in during reset.
- States:
  - IDLE:
    - If any req_in bit is set at a rising edge, select the first requester scanning last_owner+1, last_owner+2, ..., wrapping modulo N_MASTERS.
    - Register grant_out one-hot, set master_id_out, clear hold_cnt, go to GRANT.
    - Latency: request sampled at edge k gives grant visible after edge k.
  - GRANT:
    - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
    - Owner req low at an edge: go to RELEASE (normal release).
    - Else, if hold_cnt==MAX_HOLD-1 and any other req_in bit is set: go to RELEASE and pulse timeout_out for the following cycle.
    - Else, remain in GRANT. With no other requester, ownership is unbounded.
  - RELEASE:
    - grant_out=0 for exactly one cycle; last_owner=master_id_out.
    - At the end of this cycle, arbitrate exactly as in IDLE: if any request is pending, go to GRANT; otherwise go to IDLE.
- Boundary rules:
  - The released master re-requesting immediately is lowest priority, but still wins if it is the only requester.
  - Owner drops req on the same edge the timeout is reached: this is a normal release; timeout_out stays 0.
  - Requests arriving during RELEASE are eligible at the end of that same RELEASE cycle.
  - master_id_out holds the last owner while in IDLE/RELEASE.
- Decode (combinational):
  - bus_addr_out = addr_in[32*master_id_out +: 32] when |grant_out; else 0.
  - device_id_out = bus_addr_out[31:27].
  - device_sel_out = 1<<device_id_out when |grant_out; else 0.
- Width rules: hold_cnt is CNT_W bits; MAX_HOLD-1 must fit in CNT_W bits (elaboration-time check).

Test Plan:
(All with N_MASTERS=4, MAX_HOLD=8.)
1. Reset: rst=1, req_in=4'b1111 -> grant_out=0, master_id_out=0, hold_flag_out=4'b1111, device_sel_out=0. Release rst -> after first edge grant_out=4'b0001.
2. Round robin: req_in=4'b1111, each owner drops req 2 cycles after its grant and re-raises it 1 cycle later -> grant sequence 0001, 0010, 0100, 1000, 0001, with one grant_out=0 cycle between owners.
3. Preemption: masters 2 and 1 both request; master 2 owns and never drops -> grant_out=4'b0100 for 8 cycles, timeout_out=1 for one cycle, 1-cycle gap, then grant_out=4'b0010.
4. Solo hold: only master 3 requests for 20 cycles -> grant_out=4'b1000 continuously, timeout_out never asserted, hold_cnt saturates at 7.
5. Decode: master 1 owns, addr_in slice 1 = 32'hF800_0010 -> bus_addr_out=32'hF800_0010, device_id_out=31, device_sel_out=32'h8000_0000. In the gap cycle, all three outputs are 0.
6. Async reset mid-grant: rst rises between clock edges while grant_out=4'b0100 -> grant_out=0 and master_id_out=0 immediately. After release, master 0 wins first.

Source files
------------

// File: rtl/xsimbus_arbiter.sv
// xsimbus_arbiter: round-robin owner selection with bounded hold and one-cycle turnaround,
// plus owner address mux and 32-slot device decode for the xSimBus.
module xsimbus_arbiter #(
   parameter int N_MASTERS = 4,
   parameter int ID_W      = 2,
   parameter int MAX_HOLD  = 8,
   parameter int CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_MASTERS-1:0]    req_in,
   input  logic [N_MASTERS*32-1:0] addr_in,
   output logic [N_MASTERS-1:0]    grant_out,
   output logic [ID_W-1:0]         master_id_out,
   output logic [N_MASTERS-1:0]    hold_flag_out,
   output logic [31:0]             bus_addr_out,
   output logic [4:0]              device_id_out,
   output logic [31:0]             device_sel_out,
   output logic                    timeout_out
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   if (MAX_HOLD - 1 >= (1 << CNT_W)) begin : g_hold_chk
      $error("MAX_HOLD-1 does not fit in CNT_W bits");
   end

   state_t                 state, state_n;
   logic [N_MASTERS-1:0]   grant_n;
   logic [ID_W-1:0]        id_n, last_owner, last_n, pick;
   logic [CNT_W-1:0]       hold_cnt, cnt_n;
   logic                   to_n, found;
   int                     idx;

   // first requester after last_owner, wrapping
   always_comb begin
      pick = '0;
      found = 1'b0;
      idx = 0;
      for (int i = 1; i <= N_MASTERS; i++) begin
         idx = (int'(last_owner) + i) % N_MASTERS;
         if (!found && req_in[idx]) begin
            pick = ID_W'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant_out;
      id_n = master_id_out;
      cnt_n = hold_cnt;
      last_n = last_owner;
      to_n = 1'b0;
      case (state)
         GRANT: begin
            if (!req_in[master_id_out] ||
                (hold_cnt == CNT_W'(MAX_HOLD - 1) && |(req_in & ~grant_out))) begin
               state_n = RELEASE;
               grant_n = '0;
               last_n = master_id_out;
               to_n = req_in[master_id_out];
            end else if (hold_cnt != CNT_W'(MAX_HOLD - 1)) begin
               cnt_n = hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = found ? GRANT : IDLE;
            grant_n = found ? N_MASTERS'(1) << pick : '0;
            id_n = found ? pick : master_id_out;
            cnt_n = found ? '0 : hold_cnt;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant_out <= '0;
         master_id_out <= '0;
         hold_cnt <= '0;
         last_owner <= ID_W'(N_MASTERS - 1);
         timeout_out <= 1'b0;
      end else begin
         state <= state_n;
         grant_out <= grant_n;
         master_id_out <= id_n;
         hold_cnt <= cnt_n;
         last_owner <= last_n;
         timeout_out <= to_n;
      end
   end

   assign hold_flag_out = req_in & ~grant_out;
   assign bus_addr_out = |grant_out ? addr_in[{master_id_out, 5'd0} +: 32] : 32'd0;
   assign device_id_out = bus_addr_out[31:27];
   assign device_sel_out = |grant_out ? 32'd1 << device_id_out : 32'd0;
endmodule
